// File: rtl/enigma_core.sv
// enigma_core: three-rotor (I-II-III, reflector B) substitution core.
// One symbol per cycle in, ciphertext out three edges later. Each symbol
// carries its own snapshot of the rotor positions down the pipeline, so a
// position load never disturbs symbols already in flight.
module enigma_core (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_we_i,
    input  logic [14:0]        cfg_pos_i,
    input  logic signed [5:0]  input_s,
    output logic signed [5:0]  output_s,
    output logic               out_vld_o,
    output logic [14:0]        pos_o,
    output logic               cfg_err_o
);

    // Wiring tables, index 0 = A. Inverse tables are precomputed constants.
    localparam logic [4:0] ROT_I [0:25] = '{
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
        5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9};
    localparam logic [4:0] ROT_II [0:25] = '{
        5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,  5'd11, 5'd7,  5'd22,
        5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4};
    localparam logic [4:0] ROT_III [0:25] = '{
        5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
        5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,  5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
    localparam logic [4:0] REFL_B [0:25] = '{
        5'd24, 5'd17, 5'd20, 5'd7,  5'd16, 5'd18, 5'd11, 5'd3,  5'd15, 5'd23, 5'd13, 5'd6,  5'd14,
        5'd10, 5'd12, 5'd8,  5'd4,  5'd1,  5'd5,  5'd25, 5'd2,  5'd22, 5'd21, 5'd9,  5'd0,  5'd19};
    localparam logic [4:0] ROT_I_INV [0:25] = '{
        5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25, 5'd1,  5'd4,  5'd2,
        5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9};
    localparam logic [4:0] ROT_II_INV [0:25] = '{
        5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,  5'd3,  5'd10, 5'd14,
        5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13, 5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18};
    localparam logic [4:0] ROT_III_INV [0:25] = '{
        5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,  5'd20, 5'd5,  5'd21,
        5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,  5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};

    localparam logic [2:0] SEL_I       = 3'd0;
    localparam logic [2:0] SEL_II      = 3'd1;
    localparam logic [2:0] SEL_III     = 3'd2;
    localparam logic [2:0] SEL_REF     = 3'd3;
    localparam logic [2:0] SEL_I_INV   = 3'd4;
    localparam logic [2:0] SEL_II_INV  = 3'd5;
    localparam logic [2:0] SEL_III_INV = 3'd6;

    localparam logic [4:0] NOTCH_M = 5'd4;   // middle rotor notch E
    localparam logic [4:0] NOTCH_R = 5'd21;  // right rotor notch V

    // (a + b) mod 26 for operands already in 0..25: one conditional correction.
    function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        else            s = s;
        return s[4:0];
    endfunction

    // (a - b) mod 26 for operands already in 0..25; a 6-bit wrap plus 26 lands in range.
    function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (a < b) s = s + 6'd26;
        else       s = s;
        return s[4:0];
    endfunction

    function automatic logic [4:0] lut(input logic [2:0] sel, input logic [4:0] idx);
        logic [4:0] r;
        case (sel)
            SEL_I:       r = ROT_I[idx];
            SEL_II:      r = ROT_II[idx];
            SEL_III:     r = ROT_III[idx];
            SEL_REF:     r = REFL_B[idx];
            SEL_I_INV:   r = ROT_I_INV[idx];
            SEL_II_INV:  r = ROT_II_INV[idx];
            SEL_III_INV: r = ROT_III_INV[idx];
            default:     r = REFL_B[idx];
        endcase
        return r;
    endfunction

    // One rotor traversal at position p: shift in, substitute, shift back out.
    function automatic logic [4:0] rotor(input logic [2:0] sel, input logic [4:0] i, input logic [4:0] p);
        return sub26(lut(sel, add26(i, p)), p);
    endfunction

    logic [4:0] pos_l_q, pos_m_q, pos_r_q;
    logic [4:0] pos_l_d, pos_m_d, pos_r_d;
    logic       cfg_err_q, cfg_err_d;
    logic       in_ok_s, accept_s, cfg_bad_s;
    logic [4:0] cfg_l_s, cfg_m_s, cfg_r_s;

    logic       s1_vld_q;
    logic [4:0] s1_idx_q, s1_l_q, s1_m_q, s1_r_q;
    logic       s2_vld_q;
    logic [4:0] s2_idx_q, s2_l_q, s2_m_q, s2_r_q;
    logic [4:0] fwd_s, back_s;
    logic [5:0] out_sym_q;
    logic       out_vld_q;

    // Input qualification, config sanitising and rotor stepping (pre-step positions decide).
    always_comb begin
        in_ok_s   = (input_s >= 6'sd1) && (input_s <= 6'sd26);
        accept_s  = in_ok_s && !cfg_we_i;
        cfg_l_s   = (cfg_pos_i[14:10] >= 5'd26) ? 5'd0 : cfg_pos_i[14:10];
        cfg_m_s   = (cfg_pos_i[9:5]   >= 5'd26) ? 5'd0 : cfg_pos_i[9:5];
        cfg_r_s   = (cfg_pos_i[4:0]   >= 5'd26) ? 5'd0 : cfg_pos_i[4:0];
        cfg_bad_s = (cfg_pos_i[14:10] >= 5'd26) || (cfg_pos_i[9:5] >= 5'd26) ||
                    (cfg_pos_i[4:0] >= 5'd26);
        pos_l_d   = pos_l_q;
        pos_m_d   = pos_m_q;
        pos_r_d   = pos_r_q;
        cfg_err_d = 1'b0;
        if (cfg_we_i) begin
            pos_l_d   = cfg_l_s;
            pos_m_d   = cfg_m_s;
            pos_r_d   = cfg_r_s;
            cfg_err_d = cfg_bad_s;
        end else if (accept_s) begin
            pos_r_d = add26(pos_r_q, 5'd1);
            if ((pos_r_q == NOTCH_R) || (pos_m_q == NOTCH_M)) pos_m_d = add26(pos_m_q, 5'd1);
            else                                               pos_m_d = pos_m_q;
            if (pos_m_q == NOTCH_M) pos_l_d = add26(pos_l_q, 5'd1);
            else                    pos_l_d = pos_l_q;
        end else begin
            pos_r_d = pos_r_q;
        end
    end

    // Rotor position and config-error registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_l_q   <= 5'd0;
            pos_m_q   <= 5'd0;
            pos_r_q   <= 5'd0;
            cfg_err_q <= 1'b0;
        end else begin
            pos_l_q   <= pos_l_d;
            pos_m_q   <= pos_m_d;
            pos_r_q   <= pos_r_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Stage 1: capture the symbol index with its post-step position snapshot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q <= 1'b0;
            s1_idx_q <= 5'd0;
            s1_l_q   <= 5'd0;
            s1_m_q   <= 5'd0;
            s1_r_q   <= 5'd0;
        end else begin
            s1_vld_q <= accept_s;
            s1_idx_q <= input_s[4:0] - 5'd1;
            s1_l_q   <= pos_l_d;
            s1_m_q   <= pos_m_d;
            s1_r_q   <= pos_r_d;
        end
    end

    // Forward path R -> M -> L, then reflector; backward path L -> M -> R.
    always_comb begin
        fwd_s  = rotor(SEL_III, s1_idx_q, s1_r_q);
        fwd_s  = rotor(SEL_II, fwd_s, s1_m_q);
        fwd_s  = rotor(SEL_I, fwd_s, s1_l_q);
        fwd_s  = lut(SEL_REF, fwd_s);
        back_s = rotor(SEL_I_INV, s2_idx_q, s2_l_q);
        back_s = rotor(SEL_II_INV, back_s, s2_m_q);
        back_s = rotor(SEL_III_INV, back_s, s2_r_q);
    end

    // Stage 2: reflected index with positions carried along.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_vld_q <= 1'b0;
            s2_idx_q <= 5'd0;
            s2_l_q   <= 5'd0;
            s2_m_q   <= 5'd0;
            s2_r_q   <= 5'd0;
        end else begin
            s2_vld_q <= s1_vld_q;
            s2_idx_q <= fwd_s;
            s2_l_q   <= s1_l_q;
            s2_m_q   <= s1_m_q;
            s2_r_q   <= s1_r_q;
        end
    end

    // Output stage: ciphertext symbol 1..26, or 0 when nothing completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_sym_q <= 6'd0;
            out_vld_q <= 1'b0;
        end else if (s2_vld_q) begin
            out_sym_q <= {1'b0, back_s} + 6'd1;
            out_vld_q <= 1'b1;
        end else begin
            out_sym_q <= 6'd0;
            out_vld_q <= 1'b0;
        end
    end

    assign output_s  = $signed(out_sym_q);
    assign out_vld_o = out_vld_q;
    assign pos_o     = {pos_l_q, pos_m_q, pos_r_q};
    assign cfg_err_o = cfg_err_q;

endmodule

// File: doc/enigma_core.md
# enigma_core

Three-rotor substitution core sitting between the wrapper's `input_s` and `output_s` ports. It consumes one plaintext symbol per cycle, steps the rotors, encodes the symbol through right/middle/left rotors, reflector and back, and returns the ciphertext with fixed latency. The core is fully pipelined for back-to-back symbols, and start positions are loadable at run time.

## Interface
Parameters:
- none. Rotor set is fixed, ring settings are fixed at A, and symbol width is 6.

Ports:
- `clk_i`  in  1  — single clock, all logic on rising edge.
- `rst_i`  in  1  — reset, synchronous, active-high.
- `cfg_we_i`  in  1  — load start positions from `cfg_pos_i`.
- `cfg_pos_i`  in  15  — start positions: [14:10] left, [9:5] middle, [4:0] right; each 0..25.
- `input_s`  in  signed 6  — plaintext symbol. 1..26 (A..Z) is valid; any other value is idle.
- `output_s`  out  signed 6  — ciphertext symbol 1..26; 0 when no result.
- `out_vld_o`  out  1  — high for one cycle per result on `output_s`.
- `pos_o`  out  15  — current rotor positions, same packing as `cfg_pos_i`.
- `cfg_err_o`  out  1  — one-cycle pulse when a loaded field is ≥26.

## Operation
- Fixed wirings, index 0 = A:
  - Left rotor I: EKMFLGDQVZNTOWYHXUSPAIBRCJ, notch Q(16).
  - Middle rotor II: AJDKSIRUXBLHWTMCQGZNPYFVOE, notch E(4).
  - Right rotor III: BDFHJLCPRTXVZNYEIWGAKMUSQO, notch V(21).
  - Reflector B: YRUHQSLDPXNGOKMIEBFZCWVJAT.
  - Inverse tables are constant ROMs, not computed at run time.
- Stepping happens before encoding, on each accepted symbol, using the pre-step positions:
  - Right rotor always steps.
  - Middle rotor steps if right = 21, or if middle = 4 (double step).
  - Left rotor steps if middle = 4.
  - All steps are +1 mod 26; 25 wraps to 0.
- Encoding of symbol s, using the post-step positions L, M, R:
  - i = s−1.
  - Each forward rotor: i ← (W[(i+p) mod 26] − p) mod 26.
  - Reflector, then each inverse rotor in the order L, M, R with the same offset rule.
  - Output is i+1.
- Mod-26 add/subtract is done in 6-bit unsigned with one conditional ±26 correction. No division.
- Config:
  - `cfg_we_i` loads all three positions.
  - Any field ≥26 loads as 0 and raises `cfg_err_o` for one cycle.
  - `cfg_we_i` takes priority over a valid `input_s` in the same cycle: that symbol is dropped, with no step and no output.
- Symbols already in flight finish with their own snapshotted positions. A load never corrupts them.
- Idle `input_s` values (0, negatives, 27..31) cause no step and no pipeline entry.

## Timing
- Pipeline, for a symbol accepted at edge k:
  - Edge k: step positions, capture index and the post-step positions into stage 1.
  - Edge k+1: forward path plus reflector registered into stage 2, with positions carried along.
  - Edge k+2: backward path registered into `output_s`, and `out_vld_o` goes high.
- Latency is 3 edges. Throughput is 1 symbol/cycle with no stalls and no backpressure.
- `pos_o` reflects the stepped positions right after edge k.
- When no result completes at an edge, `output_s` returns to 0 and `out_vld_o` to 0.
- Reset values:
  - `output_s` = 0, `out_vld_o` = 0, `cfg_err_o` = 0.
  - `pos_o` = 0 (AAA).
  - All stage valid bits = 0.
- Reset mid-stream flushes the pipeline. No result from pre-reset symbols may appear afterwards.

## Test plan
- Reset, then `input_s` = 1 for 5 consecutive cycles → `output_s` = 2, 4, 26, 7, 15 (BDZGO) on 5 consecutive cycles starting 3 edges after the first; `pos_o` ends at 0,0,5.
- Load 0,3,20 (ADU), then three symbols → `pos_o` goes 0,3,21 → 0,4,22 → 1,5,23 (double step).
- Reload AAA, then input 2,4,26,7,15 → outputs 1,1,1,1,1 (reciprocity). Random 200-symbol check:
  - output ≠ input for every symbol;
  - result matches a reference model.
- `cfg_we_i` with `input_s` = 5 in the same cycle → no output, no step, positions loaded. Load with fields 30,0,27 → `pos_o` = 0,0,0 and a `cfg_err_o` pulse.
- Stream with idle gaps (input 0, −3, 27 between letters) → no step and `out_vld_o` = 0 for the gaps. Assert `rst_i` with 2 symbols in flight → no `out_vld_o` afterwards, and `pos_o` = 0.
